// File: rtl/sm_dmem_config_pkg.sv
// sm_dmem_config: address map, STATUS bit positions and default sizes for the data-memory responder
package sm_dmem_config;
    localparam int RAM_WORDS_DEF = 64;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam logic [31:0] ADDR_CYCLE = 32'h0000_1000;
    localparam logic [31:0] ADDR_TMRCMP = 32'h0000_1004;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_1008;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_100C;
    localparam int ST_HIT = 0;
    localparam int ST_FULL = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF = 3;
    localparam int ST_CNT = 4;
endpackage

// File: rtl/sm_fifo.sv
// sm_fifo: power-of-two word FIFO; a push into a full FIFO is taken only when a pop frees a slot in the same cycle
module sm_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic push_ok, pop_ok;

    // handshake qualification and pointer/count update; pointers wrap naturally at DEPTH
    always_comb begin
        full = count_q == CW'(DEPTH);
        empty = count_q == '0;
        pop_ok = pop && !empty;
        push_ok = push && (!full || pop_ok);
        wptr_d = wptr_q + PW'(push_ok);
        rptr_d = rptr_q + PW'(pop_ok);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        rdata = mem_q[rptr_q];
        count = count_q;
    end

    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count_q <= count_d;
        end
    end

    // storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/sm_dmem_responder.sv
// sm_dmem_responder: CPU data-memory slave with word RAM, free-running cycle counter, compare timer and TX FIFO
module sm_dmem_responder import sm_dmem_config::*; #(
    parameter int RAM_WORDS = RAM_WORDS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmAddr,
    input  logic        dmWe,
    input  logic [31:0] dmWData,
    output logic [31:0] dmRData,
    output logic [31:0] txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] mem_q [RAM_WORDS];
    logic [31:0] cycle_q, cycle_d, tmrcmp_q, tmrcmp_d, status, cnt32;
    logic hit_q, hit_d, ovf_q, ovf_d;
    logic sel_ram, ram_home, is_cyc, is_tmr, is_stat, is_tx;
    logic ram_we, tmr_we, stat_we, push, full, empty;
    logic [AW-1:0] ram_idx;
    logic [CW-1:0] count;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^dmAddr[1:0];

    sm_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .wdata(dmWData),
        .pop(txReady),
        .rdata(txData),
        .full(full),
        .empty(empty),
        .count(count)
    );

    // address decode, STATUS assembly and combinational read mux
    always_comb begin
        sel_ram = dmAddr[31:12] == '0;
        ram_home = (dmAddr[11:2] >> AW) == 10'd0;
        ram_idx = dmAddr[AW+1:2];
        is_cyc = dmAddr[31:2] == ADDR_CYCLE[31:2];
        is_tmr = dmAddr[31:2] == ADDR_TMRCMP[31:2];
        is_stat = dmAddr[31:2] == ADDR_STATUS[31:2];
        is_tx = dmAddr[31:2] == ADDR_TXDATA[31:2];
        ram_we = dmWe && sel_ram && ram_home;
        tmr_we = dmWe && is_tmr;
        stat_we = dmWe && is_stat;
        push = dmWe && is_tx;
        cnt32 = 32'(count);
        status = '0;
        status[ST_HIT] = hit_q;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF] = ovf_q;
        status[ST_CNT +: 4] = cnt32 > 32'd15 ? 4'hF : cnt32[3:0];
        dmRData = sel_ram ? mem_q[ram_idx] :
                  is_cyc  ? cycle_q :
                  is_tmr  ? tmrcmp_q :
                  is_stat ? status : '0;
        txValid = !empty;
        irq = hit_q;
    end

    // next state of counter, compare register and sticky flags; a set beats a same-cycle clear
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        tmrcmp_d = tmr_we ? dmWData : tmrcmp_q;
        hit_d = (cycle_q == tmrcmp_q) || (hit_q && !(stat_we && dmWData[ST_HIT]));
        ovf_d = (push && full && !txReady) || (ovf_q && !(stat_we && dmWData[ST_OVF]));
    end

    // control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            tmrcmp_q <= '1;
            hit_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            tmrcmp_q <= tmrcmp_d;
            hit_q <= hit_d;
            ovf_q <= ovf_d;
        end
    end

    // data RAM; not reset, but writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (ram_we && !rst) mem_q[ram_idx] <= dmWData;
    end
endmodule
